// File: rtl/change_dispenser.sv
// Change dispenser: pays out a rupee amount one hopper coin at a time using
// greedy Rs.10/5/2/1 denominations, with req/ack pacing and an ack-timeout fault.
module change_dispenser #(
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       change_valid,
    input  logic [6:0] change_amt,
    output logic       change_ready,
    input  logic       coin_ack,
    output logic       coin_req,
    output logic [1:0] coin_denom,
    output logic       busy,
    output logic       done,
    output logic [3:0] coin_count,
    output logic       fault
);

    localparam int TW       = $clog2(ACK_TIMEOUT);
    localparam int GW       = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_REQ    = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t          r_state;
    logic            r_ready;
    logic            r_req;
    logic [1:0]      r_denom;
    logic            r_busy;
    logic            r_done;
    logic [3:0]      r_count;
    logic            r_fault;
    logic [6:0]      r_remaining;
    logic [TW-1:0]   r_ack_timer;
    logic [GW-1:0]   r_gap_cnt;

    logic [6:0]      w_new_rem;
    logic            w_timeout;
    logic            w_gap_end;

    function automatic logic [1:0] pick_denom(input logic [6:0] amt);
        if (amt >= 7'd10) begin
            pick_denom = 2'd3;
        end else if (amt >= 7'd5) begin
            pick_denom = 2'd2;
        end else if (amt >= 7'd2) begin
            pick_denom = 2'd1;
        end else begin
            pick_denom = 2'd0;
        end
    endfunction

    function automatic logic [6:0] denom_value(input logic [1:0] d);
        case (d)
            2'd3:    denom_value = 7'd10;
            2'd2:    denom_value = 7'd5;
            2'd1:    denom_value = 7'd2;
            default: denom_value = 7'd1;
        endcase
    endfunction

    assign w_new_rem = r_remaining - denom_value(r_denom);
    assign w_timeout = (r_ack_timer == TW'(ACK_TIMEOUT - 1));
    assign w_gap_end = (r_gap_cnt == GW'(GAP_LAST));

    assign change_ready = r_ready;
    assign coin_req     = r_req;
    assign coin_denom   = r_denom;
    assign busy         = r_busy;
    assign done         = r_done;
    assign coin_count   = r_count;
    assign fault        = r_fault;

    // Transaction sequencer; the SELECT cycle counts as the last low cycle of
    // the inter-coin gap, so GAP itself lasts GAP_CYCLES-1 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_req       <= 1'b0;
            r_denom     <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_count     <= 4'd0;
            r_fault     <= 1'b0;
            r_remaining <= 7'd0;
            r_ack_timer <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (change_valid) begin
                        r_remaining <= change_amt;
                        r_count     <= 4'd0;
                        r_busy      <= 1'b1;
                        r_ready     <= 1'b0;
                        r_state     <= (change_amt == 7'd0) ? S_DONE : S_SELECT;
                    end
                end
                S_SELECT: begin
                    r_denom     <= pick_denom(r_remaining);
                    r_req       <= 1'b1;
                    r_ack_timer <= '0;
                    r_state     <= S_REQ;
                end
                S_REQ: begin
                    if (coin_ack) begin
                        r_req       <= 1'b0;
                        r_remaining <= w_new_rem;
                        r_count     <= r_count + 4'd1;
                        if (w_new_rem == 7'd0) begin
                            r_state <= S_DONE;
                        end else if (GAP_CYCLES == 1) begin
                            r_state <= S_SELECT;
                        end else begin
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= S_FAULT;
                    end else begin
                        r_ack_timer <= r_ack_timer + TW'(1);
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_state <= S_SELECT;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomised bench for change_dispenser: a cycle-level behavioural model built
// from coin lists and countdowns is compared against the DUT on every cycle.
module tb_change_dispenser;

    localparam int GAP = 2;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst, change_valid, change_ready, coin_ack, coin_req;
    logic [6:0] change_amt;
    logic [1:0] coin_denom;
    logic       busy, done, fault;
    logic [3:0] coin_count;

    change_dispenser #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .change_valid(change_valid), .change_amt(change_amt),
        .change_ready(change_ready), .coin_ack(coin_ack), .coin_req(coin_req),
        .coin_denom(coin_denom), .busy(busy), .done(done), .coin_count(coin_count),
        .fault(fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model: expected outputs plus the list of coins still owed.
    bit m_ready, m_req, m_busy, m_done, m_fault;
    int m_denom, m_count, m_wait, m_age, m_fin;
    int coins[$];

    // Hopper model and observation.
    int hop_delay = 1;
    bit spur_en   = 1'b0;
    int req_len = 0, low_len = 0, last_req_len = 0, n_done = 0;
    bit prev_req = 1'b0;
    int seen[$];
    int gaps[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int a;
        if (rst) begin
            m_ready = 1'b1; m_req = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_fault = 1'b0;
            m_denom = 0; m_count = 0; m_wait = 0; m_age = 0; m_fin = 0;
            coins.delete();
        end else if (!m_fault) begin
            m_done = 1'b0;
            if (m_ready) begin
                if (change_valid) begin
                    a = int'(change_amt);
                    repeat (a / 10) coins.push_back(3);
                    a = a % 10;
                    repeat (a / 5) coins.push_back(2);
                    a = a % 5;
                    repeat (a / 2) coins.push_back(1);
                    repeat (a % 2) coins.push_back(0);
                    m_count = 0; m_busy = 1'b1; m_ready = 1'b0;
                    if (coins.size() == 0) m_fin = 1;
                    else m_wait = 1;
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_req = 1'b1; m_denom = coins[0]; m_age = 0;
                end
            end else if (m_req) begin
                if (coin_ack) begin
                    m_req = 1'b0; m_count++;
                    void'(coins.pop_front());
                    if (coins.size() == 0) m_fin = 1;
                    else m_wait = GAP;
                end else if (m_age == TMO - 1) begin
                    m_req = 1'b0; m_fault = 1'b1;
                end else begin
                    m_age++;
                end
            end else if (m_fin > 0) begin
                m_fin--;
                if (m_fin == 0) begin
                    m_done = 1'b1; m_busy = 1'b0; m_ready = 1'b1;
                end
            end
        end
    endtask

    task automatic hopper_update();
        if (done) n_done++;
        if (coin_req) begin
            if (!prev_req) begin
                seen.push_back(int'(coin_denom));
                gaps.push_back(low_len);
            end
            req_len++;
            low_len  = 0;
            coin_ack = (hop_delay != 0) && (req_len >= hop_delay);
        end else begin
            if (prev_req) last_req_len = req_len;
            req_len  = 0;
            low_len++;
            coin_ack = spur_en && ($urandom_range(0, 3) == 0);
        end
        prev_req = coin_req;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        hopper_update();
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("change_ready", change_ready, m_ready);
            chk("coin_req", coin_req, m_req);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("coin_count", coin_count, m_count);
            chk("fault", fault, m_fault);
            if (m_req) chk("coin_denom", coin_denom, m_denom);
        end
    end

    task automatic send(input int amt);
        int n = 0;
        bit acc;
        change_amt   = 7'(amt);
        change_valid = 1'b1;
        do begin
            acc = m_ready;
            tick();
            n++;
        end while (!acc && n < 4000);
        change_valid = 1'b0;
        if (!acc) begin
            n_checks++; n_errors++;
            $display("FAIL send_accept: amount %0d not accepted in %0d cycles", amt, n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!m_ready && n < budget) begin
            tick();
            n++;
        end
        if (!m_ready) begin
            n_checks++; n_errors++;
            $display("FAIL wait_idle: busy after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int lat, d0, exp37[5], n_wait;
        exp37 = '{3, 3, 3, 2, 1};
        rst = 1'b1; change_valid = 1'b0; change_amt = 7'd0; coin_ack = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ready", change_ready, 1); chk("rst_req", coin_req, 0);
        chk("rst_denom", coin_denom, 0);   chk("rst_busy", busy, 0);

        // Zero change: no coin, done two cycles after the accepting cycle.
        seen.delete();
        d0 = n_done;
        send(0);
        lat = 1;
        while (!done && lat < 10) begin tick(); lat++; end
        chk("zero_done_latency", lat, 2);
        chk("zero_coins", seen.size(), 0);
        chk("zero_count", coin_count, 0);
        wait_idle(20);

        // 37 with prompt acks.
        hop_delay = 1; seen.delete(); gaps.delete(); d0 = n_done;
        send(37);
        lat = 1;
        while (!coin_req && lat < 10) begin tick(); lat++; end
        chk("first_req_latency", lat, 2);
        wait_idle(500);
        tick();
        chk("amt37_ncoins", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++) chk("amt37_denom", seen[i], exp37[i]);
        for (int i = 1; i < 5 && i < gaps.size(); i++) chk("amt37_gap", gaps[i], GAP);
        chk("amt37_count", coin_count, 5);
        chk("amt37_done_pulses", n_done - d0, 1);

        // 127 with slow acks.
        hop_delay = 3; seen.delete();
        send(127);
        wait_idle(1000);
        chk("amt127_ncoins", seen.size(), 14);
        for (int i = 0; i < 12 && i < seen.size(); i++) chk("amt127_tens", seen[i], 3);
        if (seen.size() == 14) begin
            chk("amt127_five", seen[12], 2);
            chk("amt127_two", seen[13], 1);
        end
        chk("amt127_count", coin_count, 14);

        // Hopper never acks: timeout fault, sticky until reset.
        hop_delay = 0;
        send(8);
        n_wait = 0;
        while (!m_fault && n_wait < 100) begin tick(); n_wait++; end
        repeat (5) tick();
        chk("tmo_req_len", last_req_len, TMO);
        chk("tmo_fault", fault, 1); chk("tmo_busy", busy, 1);
        chk("tmo_ready", change_ready, 0); chk("tmo_req", coin_req, 0);
        do_reset();
        chk("post_rst_fault", fault, 0); chk("post_rst_denom", coin_denom, 0);
        chk("post_rst_count", coin_count, 0); chk("post_rst_ready", change_ready, 1);

        // Ack on the final timeout cycle wins; spurious acks elsewhere ignored.
        hop_delay = TMO; spur_en = 1'b1;
        send(3);
        wait_idle(200);
        chk("late_ack_fault", fault, 0);
        chk("late_ack_count", coin_count, 2);

        // Reset mid-request, then a fresh transaction.
        hop_delay = 0;
        send(23);
        repeat (4) tick();
        chk("mid_req_active", coin_req, 1);
        do_reset();
        chk("abort_req", coin_req, 0); chk("abort_count", coin_count, 0);
        chk("abort_ready", change_ready, 1);
        hop_delay = 1; seen.delete();
        send(6);
        wait_idle(200);
        chk("amt6_ncoins", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("amt6_first", seen[0], 2);
            chk("amt6_second", seen[1], 0);
        end
        chk("amt6_count", coin_count, 2);

        // Random traffic, some back-to-back with valid held across DONE.
        for (int t = 0; t < 60; t++) begin
            hop_delay = $urandom_range(1, TMO);
            if ($urandom_range(0, 2) != 0) begin
                wait_idle(2000);
                repeat ($urandom_range(0, 3)) tick();
            end
            send($urandom_range(0, 127));
        end
        wait_idle(2000);
        repeat (3) tick();
        chk("final_fault", fault, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream stage of the vending machine FSM. Accepts the rupee change amount computed after a sale and drives the coin hopper one coin at a time, choosing greedy denominations (Rs.10/5/2/1). Handshakes with the vending machine on the input side (valid/ready) and with the hopper on the output side (req/ack). Reports completion, coins issued, and a sticky hopper fault.

Parameters:
GAP_CYCLES, 2, idle cycles with coin_req low between consecutive coins (>=1)
ACK_TIMEOUT, 16, max cycles coin_req may stay high without coin_ack before fault (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
change_valid  input  1  change_amt is valid this cycle
change_amt  input  7  change in rupees, 0..127
change_ready  output  1  block can accept a new amount
coin_ack  input  1  hopper has released the requested coin (1-cycle pulse)
coin_req  output  1  request one coin of coin_denom
coin_denom  output  2  0=Rs.1, 1=Rs.2, 2=Rs.5, 3=Rs.10
busy  output  1  transaction in progress
done  output  1  1-cycle pulse: transaction finished, all change issued
coin_count  output  4  coins issued in current/last transaction (max 14)
fault  output  1  sticky: hopper ack timeout

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, on port rst. rst has priority over every other input.
- Reset values: state IDLE, coin_req 0, coin_denom 0, busy 0, done 0, coin_count 0, fault 0, remaining 0, timers 0. change_ready is 1 whenever state is IDLE (including the cycle after reset).
- States: IDLE, SELECT, REQ, GAP, DONE, FAULT.
- IDLE: change_ready=1. On change_valid&&change_ready: latch change_amt into 7-bit remaining, clear coin_count, busy<=1. Go to DONE if change_amt==0, else SELECT.
- SELECT (1 cycle): coin_denom <= largest of 10/5/2/1 that is <= remaining. coin_req<=1, ack timer<=0, go REQ. First coin_req is high 2 cycles after the accept edge.
- REQ: coin_req and coin_denom held stable. The ack timer increments each cycle.
  - On coin_ack: coin_req<=0, remaining -= denom value, coin_count += 1. If new remaining==0 go DONE, else GAP with gap counter<=0.
  - If there is no ack and the timer reaches ACK_TIMEOUT-1: coin_req<=0, fault<=1, go FAULT.
  - If ack arrives on the timeout cycle, the ack wins.
- GAP: coin_req=0 for exactly GAP_CYCLES cycles, then SELECT.
- DONE (1 cycle): done=1, busy<=0, return to IDLE. coin_count holds until the next accept.
- FAULT: busy stays 1, change_ready=0, coin_req=0. Stays until rst; no other exit.
- coin_ack outside REQ is ignored (no count change, no fault).
- change_valid outside IDLE is ignored. The upstream must hold valid until ready. Valid held through DONE->IDLE is accepted on the IDLE cycle (back-to-back transactions allowed).
- Reset mid-transaction aborts immediately. No partial-coin recovery; the hopper must drop any pending dispense on rst.
- Arithmetic: remaining never underflows, because the denom is always <= remaining. Max coins = 12x10 + 5 + 2 = 14, which fits in 4 bits.

Test Plan:
1. Reset, then change_amt=0 with valid -> no coin_req. done pulses 2 cycles after the accept edge. coin_count=0, busy returns to 0.
2. change_amt=37, hopper acks 1 cycle after each req -> coin sequence denom 3,3,3,2,1 (10,10,10,5,2). coin_req low exactly GAP_CYCLES between coins. coin_count=5, one done pulse.
3. change_amt=127, ack delayed 3 cycles each -> twelve denom-3 coins, then one denom-2, then one denom-1. coin_count=14, coin_req stable while waiting.
4. change_amt=8, hopper never acks -> coin_req drops after ACK_TIMEOUT cycles. fault=1, busy=1, change_ready=0 held. Then rst -> all outputs at reset values.
5. Ack coincident with the final timeout cycle -> coin counted, no fault. Also: a spurious coin_ack in GAP/IDLE has no effect on coin_count.
6. rst asserted mid-REQ of a 23-rupee transaction -> next cycle IDLE, coin_req=0, coin_count=0. A new valid of 6 is then accepted and issues 5,1.
